// File: rtl/seg7_write_arbiter_if.sv
// CPU store port, auxiliary master handshake and display register drive for seg7_write_arbiter.
interface seg7_write_arbiter_if #(
  parameter int ANCHO = 32
);
  logic [ANCHO-1:0] cpu_dir;
  logic [ANCHO-1:0] cpu_dato;
  logic             cpu_we;
  logic             cpu_stall;
  logic [ANCHO-1:0] cpu_rdato;
  logic             aux_req;
  logic [ANCHO-1:0] aux_dato;
  logic             aux_gnt;
  logic [ANCHO-1:0] disp_dato;
  logic             disp_we;

  modport master (
    output cpu_dir, cpu_dato, cpu_we, aux_req, aux_dato,
    input  cpu_stall, cpu_rdato, aux_gnt, disp_dato, disp_we
  );

  modport slave (
    input  cpu_dir, cpu_dato, cpu_we, aux_req, aux_dato,
    output cpu_stall, cpu_rdato, aux_gnt, disp_dato, disp_we
  );
endinterface

// File: rtl/seg7_write_arbiter.sv
// Round-robin write arbiter for the 7-segment display register (CPU store port vs auxiliary master).
// Define SEG7_GUARD_EN to hold off further grants for GUARD cycles after each write.
module seg7_write_arbiter #(
  parameter int               ANCHO    = 32,
  parameter logic [ANCHO-1:0] DIR_DISP = 'h30C,
  parameter int               GUARD    = 4
) (
  input logic                clk,
  input logic                rst,
  seg7_write_arbiter_if.slave bus
);

  typedef enum logic {SRC_CPU, SRC_AUX} src_t;

  logic             pend_v;
  logic [ANCHO-1:0] pend_d;
  src_t             last_src;
  logic             hit;
  logic             cand_cpu;
  logic             cand_aux;
  logic             can_grant;
  logic             win_cpu;
  logic             win_aux;
  logic             capture;

`ifdef SEG7_GUARD_EN
  localparam int CW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  typedef enum logic {S_IDLE, S_GUARD} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // GUARD=0 never leaves IDLE, matching the guard-less build.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if ((win_cpu || win_aux) && (GUARD > 0)) begin
          state_nx = S_GUARD;
          cnt_nx   = CW'(GUARD - 1);
        end
      end
      S_GUARD: begin
        if (cnt == '0) state_nx = S_IDLE;
        else           cnt_nx   = cnt - CW'(1);
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign can_grant = (state == S_IDLE);
`else
  // GUARD only matters when the guard interval is compiled in.
  if (GUARD < 0) begin : g_guard_unused
  end

  assign can_grant = 1'b1;
`endif

  always_comb begin
    hit      = bus.cpu_we && (bus.cpu_dir == DIR_DISP);
    cand_cpu = pend_v;
    // aux_req is still high in the grant cycle; that request was already served.
    cand_aux = bus.aux_req && !bus.aux_gnt;
    win_cpu  = can_grant && cand_cpu && (!cand_aux || (last_src == SRC_AUX));
    win_aux  = can_grant && cand_aux && (!cand_cpu || (last_src == SRC_CPU));
    capture  = hit && (!pend_v || win_cpu);
  end

  assign bus.cpu_stall = hit && pend_v && !win_cpu;
  assign bus.cpu_rdato = bus.disp_dato;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_v        <= 1'b0;
      pend_d        <= '0;
      last_src      <= SRC_AUX;
      bus.disp_we   <= 1'b0;
      bus.disp_dato <= '0;
      bus.aux_gnt   <= 1'b0;
    end else begin
      if (capture) begin
        pend_v <= 1'b1;
        pend_d <= bus.cpu_dato;
      end else if (win_cpu) begin
        pend_v <= 1'b0;
      end

      bus.disp_we <= win_cpu || win_aux;
      bus.aux_gnt <= win_aux;

      if (win_cpu) begin
        bus.disp_dato <= pend_d;
        last_src      <= SRC_CPU;
      end else if (win_aux) begin
        bus.disp_dato <= bus.aux_dato;
        last_src      <= SRC_AUX;
      end
    end
  end

endmodule

// File: tb/tb_seg7_write_arbiter.sv
// Directed self-checking bench for seg7_write_arbiter; pulse spacing follows SEG7_GUARD_EN.
module tb_seg7_write_arbiter;

`ifdef SEG7_GUARD_EN
  localparam int GAP1    = 5;
  localparam int AUX_GAP = 5;
`else
  localparam int GAP1    = 1;
  localparam int AUX_GAP = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  seg7_write_arbiter_if #(.ANCHO(32)) bus ();

  seg7_write_arbiter #(
    .ANCHO   (32),
    .DIR_DISP(32'h30C),
    .GUARD   (4)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  // Ticks until disp_we is seen high or max ticks pass; n is the tick count.
  task automatic wait_we(input int max, output int n, output bit found);
    n = 0;
    found = 1'b0;
    while (!found && n < max) begin
      tick();
      n++;
      if (bus.disp_we === 1'b1) found = 1'b1;
    end
    if (!found) n = max + 1;
  endtask

  task automatic cpu_write(input logic [31:0] dir, input logic [31:0] d);
    bus.cpu_we   = 1'b1;
    bus.cpu_dir  = dir;
    bus.cpu_dato = d;
  endtask

  initial begin
    int n;
    bit found;

    rst_n        = 1'b0;
    bus.aux_req  = 1'b0;
    bus.aux_dato = '0;
    cpu_write(32'h30C, 32'hDEAD0001);

    // Reset with a CPU hit pending on the bus
    idle(2);
    check("rst_we",    32'(bus.disp_we),   32'd0);
    check("rst_gnt",   32'(bus.aux_gnt),   32'd0);
    check("rst_dato",  bus.disp_dato,      32'h0);
    check("rst_rdato", bus.cpu_rdato,      32'h0);
    check("rst_stall", 32'(bus.cpu_stall), 32'd0);
    rst_n = 1'b1;
    tick();
    bus.cpu_we = 1'b0;
    check("rst_first_early", 32'(bus.disp_we), 32'd0);
    tick();
    check("rst_first_we",   32'(bus.disp_we), 32'd1);
    check("rst_first_dato", bus.disp_dato,    32'hDEAD0001);
    idle(8);

    // Single CPU write, then a non-display address
    cpu_write(32'h30C, 32'h12345678);
    tick();
    bus.cpu_we = 1'b0;
    check("single_early", 32'(bus.disp_we), 32'd0);
    tick();
    check("single_we",    32'(bus.disp_we), 32'd1);
    check("single_dato",  bus.disp_dato,    32'h12345678);
    check("single_rdato", bus.cpu_rdato,    32'h12345678);
    tick();
    check("single_pulse_len", 32'(bus.disp_we), 32'd0);
    idle(8);
    cpu_write(32'h308, 32'h55555555);
    tick();
    bus.cpu_we = 1'b0;
    wait_we(6, n, found);
    check("miss_no_pulse", 32'(found),   32'd0);
    check("miss_dato",     bus.disp_dato, 32'h12345678);

    // Tie right after reset: CPU first, then aux
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    cpu_write(32'h30C, 32'hAAAA0000);
    tick();
    bus.cpu_we   = 1'b0;
    bus.aux_req  = 1'b1;
    bus.aux_dato = 32'h0000BBBB;
    tick();
    check("tie_cpu_we",   32'(bus.disp_we), 32'd1);
    check("tie_cpu_dato", bus.disp_dato,    32'hAAAA0000);
    check("tie_cpu_gnt",  32'(bus.aux_gnt), 32'd0);
    wait_we(12, n, found);
    check("tie_aux_gap",  32'(n),           32'(GAP1));
    check("tie_aux_gnt",  32'(bus.aux_gnt), 32'd1);
    check("tie_aux_dato", bus.disp_dato,    32'h0000BBBB);
    bus.aux_req = 1'b0;
    tick();
    check("tie_gnt_len", 32'(bus.aux_gnt), 32'd0);
    check("tie_we_len",  32'(bus.disp_we), 32'd0);
    idle(8);

    // Continuous aux request: fixed pulse spacing
    bus.aux_req  = 1'b1;
    bus.aux_dato = 32'h0000C0DE;
    wait_we(12, n, found);
    check("cont_first", 32'(found), 32'd1);
    for (int i = 0; i < 3; i++) begin
      wait_we(12, n, found);
      check("cont_gap", 32'(n),           32'(AUX_GAP));
      check("cont_gnt", 32'(bus.aux_gnt), 32'd1);
    end
    bus.aux_req = 1'b0;
    idle(8);

    // Stall: buffer full while CPU cannot be granted
    cpu_write(32'h30C, 32'h11110000);
    tick();
    bus.cpu_dato = 32'h11110001;
    tick();
    check("stall_w0_we",   32'(bus.disp_we), 32'd1);
    check("stall_w0_dato", bus.disp_dato,    32'h11110000);
    bus.cpu_dato = 32'h11110002;
    bus.aux_req  = 1'b1;
    bus.aux_dato = 32'hA5A5A5A5;
    #1;
    check("stall_high", 32'(bus.cpu_stall), 32'd1);
    wait_we(12, n, found);
    check("stall_aux_gap",  32'(n),           32'(GAP1));
    check("stall_aux_gnt",  32'(bus.aux_gnt), 32'd1);
    check("stall_aux_dato", bus.disp_dato,    32'hA5A5A5A5);
    bus.aux_req = 1'b0;
    wait_we(12, n, found);
    check("stall_w1_gap",  32'(n),           32'(GAP1));
    check("stall_w1_dato", bus.disp_dato,    32'h11110001);
    check("stall_w1_gnt",  32'(bus.aux_gnt), 32'd0);
    bus.cpu_we = 1'b0;
    #1;
    check("stall_low", 32'(bus.cpu_stall), 32'd0);
    wait_we(12, n, found);
    check("stall_w2_gap",  32'(n),        32'(GAP1));
    check("stall_w2_dato", bus.disp_dato, 32'h11110002);
    idle(8);

    // Reset with an in-flight pulse and a pending CPU write
    cpu_write(32'h30C, 32'h99990009);
    tick();
    bus.cpu_dato = 32'h88880008;
    tick();
    check("midrst_pre_we", 32'(bus.disp_we), 32'd1);
    bus.cpu_we = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_we",    32'(bus.disp_we),   32'd0);
    check("midrst_dato",  bus.disp_dato,      32'h0);
    check("midrst_rdato", bus.cpu_rdato,      32'h0);
    check("midrst_gnt",   32'(bus.aux_gnt),   32'd0);
    check("midrst_stall", 32'(bus.cpu_stall), 32'd0);
    #1;
    rst_n = 1'b1;
    wait_we(12, n, found);
    check("midrst_no_ghost", 32'(found),   32'd0);
    check("midrst_dato_end", bus.disp_dato, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_write_arbiter.md
# seg7_write_arbiter

Write arbiter and sequencer for the memory-mapped 7-segment display register. Shares the display data register between the CPU store port, which is address-decoded at the display address, and an auxiliary master such as a debug or monitor engine. One write per grant, round-robin fairness between the two sources, and an optional guard interval so every displayed value stays visible for a minimum time. Outputs drive the display register's data input and write-enable directly.

## Interface
- ANCHO, 32, data and address width.
- DIR_DISP, 'h30C, CPU address that selects the display register.
- GUARD, 4, minimum cycles the display spends in GUARD after each write (only with SEG7_GUARD_EN).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cpu_dir  in  ANCHO  CPU address.
- cpu_dato  in  ANCHO  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_stall  out  1  combinational; CPU must hold its write this cycle.
- cpu_rdato  out  ANCHO  readback of the last value issued to the display.
- aux_req  in  1  auxiliary write request, level.
- aux_dato  in  ANCHO  auxiliary data, stable while aux_req=1.
- aux_gnt  out  1  one-cycle grant pulse, registered.
- disp_dato  out  ANCHO  data to the display register, holds the last issued value.
- disp_we  out  1  one-cycle write pulse to the display register, registered.

## Operation
- CPU hit: cpu_we=1 and cpu_dir==DIR_DISP. Other addresses are ignored.
- Pending buffer: one entry (pend_v, pend_d).
  - A hit is captured at the clock edge when pend_v=0, or when the pending entry is being issued at that same edge.
- cpu_stall = hit & pend_v & !(CPU granted this edge).
- Candidates at a decision: CPU if pend_v=1; aux if aux_req=1 and aux_gnt=0. A stale request during the grant cycle is ignored.
- Round-robin: last_src flag.
  - With a single candidate, that candidate wins.
  - With both candidates, the one not equal to last_src wins.
  - last_src updates on every grant. Reset value is AUX, so the CPU wins the first tie.
- FSM states: IDLE, GUARD.
  - IDLE, with a candidate: at the edge, register disp_we=1, disp_dato=winner data, and aux_gnt=1 if the winner is aux. If the winner is CPU, clear pend_v (unless refilled at the same edge). Go to GUARD with cnt=GUARD-1.
  - IDLE, no candidate: stay in IDLE. disp_we=0, aux_gnt=0.
  - GUARD: no grants. cnt decrements each cycle. At cnt==0, go to IDLE at the next edge.
  - CPU hits are still captured into an empty buffer while in GUARD.
- cpu_rdato = disp_dato.
- Reset values: state IDLE, pend_v=0, pend_d=0, disp_dato=0, disp_we=0, aux_gnt=0, cnt=0, last_src=AUX, cpu_stall=0.
- Reset mid-operation: a pending CPU write is discarded. An in-flight disp_we or aux_gnt pulse is cleared immediately (asynchronous reset).

## Timing
- Latency: a decision in IDLE at edge k puts disp_we and aux_gnt high during cycle k+1 only.
- A CPU hit captured at edge k is issued, if IDLE and it wins, with disp_we high in cycle k+2.
- Guard enabled: pulse-to-pulse spacing is at least GUARD+1 cycles.
- Guard disabled: back-to-back pulses every cycle are possible; two requesters alternate.
- Aux handshake: aux_req and aux_dato are held until aux_gnt is sampled high. The aux master may re-request immediately, but the arbiter ignores aux_req in the grant cycle.
- Counter width: $clog2(GUARD+1). GUARD=0 behaves exactly as if the guard were disabled.

## Configuration
- SEG7_GUARD_EN defined:
  - GUARD state and counter are compiled in.
  - After each write the FSM spends GUARD cycles in GUARD before returning to IDLE.
- SEG7_GUARD_EN undefined:
  - No GUARD state or counter; the GUARD parameter is unused.
  - After each write the FSM stays in IDLE and can grant again at the next edge.

## Test plan
- Reset: hold rst=0 with cpu_we=1, cpu_dir='h30C -> all outputs 0. After release, first disp_we only 2 cycles after a hit.
- Single CPU write: 'h12345678 to 'h30C -> disp_we pulse 2 cycles later, disp_dato=cpu_rdato='h12345678. A write to 'h308 produces no pulse.
- Tie after reset: pending CPU 'hAAAA0000 and aux_req with 'h0000BBBB -> CPU issued first, then aux. aux_gnt high for exactly one cycle.
- Guard (SEG7_GUARD_EN, GUARD=4): continuous aux_req -> disp_we pulses exactly 5 cycles apart. Without the macro, the same stimulus gives a pulse every 2 cycles (stale-request rule).
- Stall: buffer full during GUARD, second CPU hit -> cpu_stall=1 until the pending entry issues. The held write is captured at the issue edge.
- Reset mid-GUARD with a pending CPU write -> pend_v=0, state IDLE, disp_dato=0, and no later pulse for the discarded write.
